// File: rtl/alu_wb_stage.sv
// -----------------------------------------------------------------------------
// alu_wb_stage
//   Writeback stage downstream of the 2x2 ALU. Accepts one result bundle per
//   valid/ready handshake, holds it, and sequences it into a single-write-port
//   register file (MUL: two beats, rd0<=q0 then rd1<=q1; other valid ops: one
//   beat). Maintains the architectural {N,Z,C,V} flag register, updated with
//   the held status/mask on the edge at which the op's last beat is accepted.
//
// Parameters
//   REG_ADDR_W  register-file index width (default 5)
//   DATA_W      result word width, fixed at 32 for ALU compatibility
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready bundle handshake
//   in_op             ALU opcode (0x00 NOP, 0x01..0x11 valid, 0x04 MUL,
//                     >=0x12 undefined)
//   in_q0/in_q1       primary / secondary (MUL high) result
//   in_st, in_fmask   status {N,Z,C,V} and per-bit flag update enable
//   in_rd0/in_rd1     destinations for q0 / q1
//   wr_valid/wr_ready register-file write handshake
//   wr_addr/wr_data   write index / data (registered)
//   flags             architectural flags {N,Z,C,V}
//   bad_op            sticky undefined-opcode indicator, cleared by rst only
//
// Build option
//   ALU_WB_BYPASS_EN  adds byp_valid/byp_addr/byp_data, mirroring each
//                     accepted write beat for upstream operand forwarding.
// -----------------------------------------------------------------------------
module alu_wb_stage #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_op,
    input  logic [DATA_W-1:0]     in_q0,
    input  logic [DATA_W-1:0]     in_q1,
    input  logic [3:0]            in_st,
    input  logic [REG_ADDR_W-1:0] in_rd0,
    input  logic [REG_ADDR_W-1:0] in_rd1,
    input  logic [3:0]            in_fmask,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic [3:0]            flags,
    output logic                  bad_op
`ifdef ALU_WB_BYPASS_EN
    ,
    output logic                  byp_valid,
    output logic [REG_ADDR_W-1:0] byp_addr,
    output logic [DATA_W-1:0]     byp_data
`endif
);

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_MUL     = 8'h04;
    localparam logic [7:0] OP_LAST_OK = 8'h11;

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1
    } state_e;

    state_e                  state_q;
    logic [7:0]              op_q;
    logic [DATA_W-1:0]       q1_q;
    logic [REG_ADDR_W-1:0]   rd1_q;
    logic [3:0]              st_q;
    logic [3:0]              fmask_q;
    logic                    wr_valid_q;
    logic [REG_ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]       wr_data_q;
    logic [3:0]              flags_q;
    logic [3:0]              flags_d;
    logic                    bad_op_q;

    logic last_beat;
    logic retire;
    logic accept;
    logic in_op_writes;
    logic in_op_bad;

    always_comb begin
        last_beat    = (state_q == BEAT1) || ((state_q == BEAT0) && (op_q != OP_MUL));
        retire       = last_beat && wr_ready;
        in_ready     = (state_q == IDLE) || retire;
        accept       = in_valid && in_ready;
        in_op_writes = (in_op != OP_NOP) && (in_op <= OP_LAST_OK);
        in_op_bad    = (in_op > OP_LAST_OK);
        // Flag merge always uses the held bundle, so a NOP/bad op accepted on
        // the retiring edge cannot disturb the retiring op's update.
        flags_d      = (flags_q & ~fmask_q) | (st_q & fmask_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            q1_q       <= '0;
            rd1_q      <= '0;
            st_q       <= '0;
            fmask_q    <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            flags_q    <= '0;
            bad_op_q   <= 1'b0;
        end else begin
            if (retire) begin
                flags_q <= flags_d;
            end

            if ((state_q == BEAT0) && (op_q == OP_MUL) && wr_ready) begin
                state_q   <= BEAT1;
                wr_addr_q <= rd1_q;
                wr_data_q <= q1_q;
            end else if ((state_q == IDLE) || retire) begin
                // Free slot: either reload BEAT0 from a new bundle or go idle.
                if (accept && in_op_writes) begin
                    state_q    <= BEAT0;
                    wr_valid_q <= 1'b1;
                    wr_addr_q  <= in_rd0;
                    wr_data_q  <= in_q0;
                    op_q       <= in_op;
                    q1_q       <= in_q1;
                    rd1_q      <= in_rd1;
                    st_q       <= in_st;
                    fmask_q    <= in_fmask;
                end else begin
                    state_q    <= IDLE;
                    wr_valid_q <= 1'b0;
                end
                if (accept && in_op_bad) begin
                    bad_op_q <= 1'b1;
                end
            end
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign flags    = flags_q;
    assign bad_op   = bad_op_q;

`ifdef ALU_WB_BYPASS_EN
    assign byp_valid = wr_valid_q && wr_ready;
    assign byp_addr  = wr_addr_q;
    assign byp_data  = wr_data_q;
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_wb_stage
//   Directed, table-driven bench for alu_wb_stage. Each record holds the inputs
//   driven for one clock cycle plus the expected in_ready before the edge and
//   the expected registered outputs after it.
// -----------------------------------------------------------------------------
module tb_alu_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_op;
    logic [31:0] in_q0;
    logic [31:0] in_q1;
    logic [3:0]  in_st;
    logic [4:0]  in_rd0;
    logic [4:0]  in_rd1;
    logic [3:0]  in_fmask;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  flags;
    logic        bad_op;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    alu_wb_stage #(.REG_ADDR_W(5), .DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_q0    (in_q0),
        .in_q1    (in_q1),
        .in_st    (in_st),
        .in_rd0   (in_rd0),
        .in_rd1   (in_rd1),
        .in_fmask (in_fmask),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .flags    (flags),
        .bad_op   (bad_op)
    );

    typedef struct {
        logic        rst;
        logic        v;
        logic [7:0]  op;
        logic [31:0] q0;
        logic [31:0] q1;
        logic [3:0]  st;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic [3:0]  fm;
        logic        wrdy;
        logic        e_rdy;
        logic        e_wv;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [3:0]  e_fl;
        logic        e_bad;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic v, input logic [7:0] op,
        input logic [31:0] q0, input logic [31:0] q1, input logic [3:0] st,
        input logic [4:0] rd0, input logic [4:0] rd1, input logic [3:0] fm,
        input logic wrdy, input logic e_rdy, input logic e_wv,
        input logic [4:0] e_wa, input logic [31:0] e_wd,
        input logic [3:0] e_fl, input logic e_bad);
        vec_t t;
        t.rst = r; t.v = v; t.op = op; t.q0 = q0; t.q1 = q1; t.st = st;
        t.rd0 = rd0; t.rd1 = rd1; t.fm = fm; t.wrdy = wrdy;
        t.e_rdy = e_rdy; t.e_wv = e_wv; t.e_wa = e_wa; t.e_wd = e_wd;
        t.e_fl = e_fl; t.e_bad = e_bad;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        //              rst v  op     q0            q1            st       rd0 rd1 fm       wrdy rdy wv wa  wd            fl       bad
        // ADD, one beat
        vecs.push_back(mk(0, 1, 8'h01, 32'h5,        32'h0,        4'b0000, 3,  0,  4'hF,    1,   1,  1, 3,  32'h5,        4'b0000, 0));
        vecs.push_back(mk(0, 0, 8'h00, 32'h0,        32'h0,        4'b0000, 0,  0,  4'h0,    1,   1,  0, 0,  32'h0,        4'b0000, 0));
        // MUL with two stall cycles in BEAT0; a SUB is offered but must wait
        vecs.push_back(mk(0, 1, 8'h04, 32'h0,        32'h1,        4'b0010, 4,  5,  4'hF,    0,   1,  1, 4,  32'h0,        4'b0000, 0));
        vecs.push_back(mk(0, 1, 8'h02, 32'h11,       32'h0,        4'b1000, 1,  0,  4'b1100, 0,   0,  1, 4,  32'h0,        4'b0000, 0));
        vecs.push_back(mk(0, 1, 8'h02, 32'h11,       32'h0,        4'b1000, 1,  0,  4'b1100, 0,   0,  1, 4,  32'h0,        4'b0000, 0));
        vecs.push_back(mk(0, 1, 8'h02, 32'h11,       32'h0,        4'b1000, 1,  0,  4'b1100, 1,   0,  1, 5,  32'h1,        4'b0000, 0));
        // MUL retires, SUB accepted on the same edge
        vecs.push_back(mk(0, 1, 8'h02, 32'h11,       32'h0,        4'b1000, 1,  0,  4'b1100, 1,   1,  1, 1,  32'h11,       4'b0010, 0));
        // AND back-to-back; only N,Z follow status
        vecs.push_back(mk(0, 1, 8'h03, 32'h22,       32'h0,        4'b0100, 2,  0,  4'b1100, 1,   1,  1, 2,  32'h22,       4'b1010, 0));
        vecs.push_back(mk(0, 0, 8'h00, 32'h0,        32'h0,        4'b0000, 0,  0,  4'h0,    1,   1,  0, 0,  32'h0,        4'b0110, 0));
        // undefined op then NOP: no writes, bad_op sticky
        vecs.push_back(mk(0, 1, 8'h20, 32'hDEADBEEF, 32'h0,        4'b1111, 9,  0,  4'hF,    1,   1,  0, 0,  32'h0,        4'b0110, 1));
        vecs.push_back(mk(0, 1, 8'h00, 32'h55,       32'h0,        4'b1111, 6,  0,  4'hF,    1,   1,  0, 0,  32'h0,        4'b0110, 1));
        vecs.push_back(mk(0, 0, 8'h00, 32'h0,        32'h0,        4'b0000, 0,  0,  4'h0,    1,   1,  0, 0,  32'h0,        4'b0110, 1));
        // ADD then NOP accepted on its retiring edge: V still updates
        vecs.push_back(mk(0, 1, 8'h01, 32'h33,       32'h0,        4'b0001, 8,  0,  4'b0001, 1,   1,  1, 8,  32'h33,       4'b0110, 1));
        vecs.push_back(mk(0, 1, 8'h00, 32'h0,        32'h0,        4'b1111, 0,  0,  4'hF,    1,   1,  0, 0,  32'h0,        4'b0111, 1));
        // boundary: 0x11 writes, 0x12 does not (fmask 0 keeps flags)
        vecs.push_back(mk(0, 1, 8'h11, 32'hA5,       32'h0,        4'b1111, 31, 0,  4'h0,    1,   1,  1, 31, 32'hA5,       4'b0111, 1));
        vecs.push_back(mk(0, 1, 8'h12, 32'h99,       32'h0,        4'b1111, 1,  0,  4'hF,    1,   1,  0, 0,  32'h0,        4'b0111, 1));
        // MUL rd0==rd1, reset while BEAT1 stalls: q1 never accepted
        vecs.push_back(mk(0, 1, 8'h04, 32'hAAAA,     32'hBBBB,     4'b1000, 6,  6,  4'b1000, 1,   1,  1, 6,  32'hAAAA,     4'b0111, 1));
        vecs.push_back(mk(0, 0, 8'h00, 32'h0,        32'h0,        4'b0000, 0,  0,  4'h0,    1,   0,  1, 6,  32'hBBBB,     4'b0111, 1));
        vecs.push_back(mk(1, 0, 8'h00, 32'h0,        32'h0,        4'b0000, 0,  0,  4'h0,    0,   0,  0, 0,  32'h0,        4'b0000, 0));
        vecs.push_back(mk(0, 0, 8'h00, 32'h0,        32'h0,        4'b0000, 0,  0,  4'h0,    1,   1,  0, 0,  32'h0,        4'b0000, 0));
        // 0x12 is the first undefined opcode
        vecs.push_back(mk(0, 1, 8'h12, 32'h99,       32'h0,        4'b1111, 1,  0,  4'hF,    1,   1,  0, 0,  32'h0,        4'b0000, 1));
        vecs.push_back(mk(0, 0, 8'h00, 32'h0,        32'h0,        4'b0000, 0,  0,  4'h0,    1,   1,  0, 0,  32'h0,        4'b0000, 1));

        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_q0 = '0; in_q1 = '0;
        in_st = '0; in_rd0 = '0; in_rd1 = '0; in_fmask = '0; wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset flags",    {28'h0, flags},    32'h0);
        chk("reset wr_valid", {31'h0, wr_valid}, 32'h0);
        chk("reset in_ready", {31'h0, in_ready}, 32'h1);
        chk("reset bad_op",   {31'h0, bad_op},   32'h0);
        chk("reset wr_addr",  {27'h0, wr_addr},  32'h0);
        chk("reset wr_data",  wr_data,           32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst      = vecs[i].rst;
            in_valid = vecs[i].v;
            in_op    = vecs[i].op;
            in_q0    = vecs[i].q0;
            in_q1    = vecs[i].q1;
            in_st    = vecs[i].st;
            in_rd0   = vecs[i].rd0;
            in_rd1   = vecs[i].rd1;
            in_fmask = vecs[i].fm;
            wr_ready = vecs[i].wrdy;
            #1;
            chk($sformatf("v%0d in_ready", i), {31'h0, in_ready}, {31'h0, vecs[i].e_rdy});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d wr_valid", i), {31'h0, wr_valid}, {31'h0, vecs[i].e_wv});
            chk($sformatf("v%0d flags", i),    {28'h0, flags},    {28'h0, vecs[i].e_fl});
            chk($sformatf("v%0d bad_op", i),   {31'h0, bad_op},   {31'h0, vecs[i].e_bad});
            if (vecs[i].e_wv || vecs[i].rst) begin
                chk($sformatf("v%0d wr_addr", i), {27'h0, wr_addr}, {27'h0, vecs[i].e_wa});
                chk($sformatf("v%0d wr_data", i), wr_data,          vecs[i].e_wd);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
